uart_tx_controller: RTL and testbench

//  Sequences the 11-bit UART shift register for transmission: accepts one byte

---
 rtl/uart_tx_controller_if.sv | 19 +
 rtl/uart_tx_controller.sv | 131 +++++++++++++
 tb/tb_uart_tx_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_controller_if.sv
// Host-side byte handshake between a byte source and the UART TX controller.
// The source drives data/valid; the controller answers with ready/busy/done.
interface uart_tx_controller_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_controller.sv
// Sequences an external 11-bit UART shift register: accepts a byte, presents the
// framed word, then issues one load strobe and ten baud-paced shift strobes.
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    uart_tx_controller_if.slave        host,
    output logic                       sr_load_o,
    output logic                       sr_shift_o,
    output logic [10:0]                sr_data_p_o,
    output logic                       sr_data_s_o,
    input  logic                       sr_q0_i,
    output logic                       tx_o
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     LAST_BIT  = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_vld_q, frame_vld_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          load_q, load_d;
    logic          shift_q, shift_d;
    logic          done_q, done_d;
    logic          parity_bit;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q;
        byte_d      = byte_q;
        frame_vld_d = frame_vld_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.tx_valid) begin
                    byte_d      = host.tx_data;
                    frame_vld_d = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                bit_idx_d = 4'd0;
                baud_d    = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from next-state so they line up with the state they describe.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        load_d  = (state_d == LOAD);
        shift_d = (state_d == SEND) && (baud_d == BAUD_LAST) && (bit_idx_d != LAST_BIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            bit_idx_q   <= 4'd0;
            baud_q      <= '0;
            byte_q      <= 8'h00;
            frame_vld_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            shift_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            baud_q      <= baud_d;
            byte_q      <= byte_d;
            frame_vld_q <= frame_vld_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            load_q      <= load_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
        end
    end

    assign parity_bit = PARITY_EN ? ((^byte_q) ^ PARITY_ODD) : 1'b1;

    // Until a byte has been accepted the register is offered an all-idle word.
    assign sr_data_p_o = frame_vld_q ? {1'b1, parity_bit, byte_q, 1'b0} : 11'h7FF;
    assign sr_data_s_o = 1'b1;
    assign sr_load_o   = load_q;
    assign sr_shift_o  = shift_q;

    // Gating by state keeps stale register content off the line and lets reset
    // pull the line high without waiting for a clock edge.
    assign tx_o = (state_q == SEND) ? sr_q0_i : 1'b1;

    assign host.tx_ready = ready_q;
    assign host.tx_busy  = busy_q;
    assign host.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Drives three controller configurations, each feeding a behavioural shift
// register, and compares every output on every cycle against a timing model.
module tb_uart_tx_controller;

    localparam int NL = 3;
    localparam int CPB_L [NL] = '{4, 5, 2};
    localparam bit PEN_L [NL] = '{1'b1, 1'b1, 1'b0};
    localparam bit ODD_L [NL] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  tx_data  [NL];
    logic        tx_valid [NL];
    logic        tx_ready [NL];
    logic        tx_busy  [NL];
    logic        tx_done  [NL];
    logic        sr_load  [NL];
    logic        sr_shift [NL];
    logic        sr_s     [NL];
    logic        sr_q0    [NL];
    logic        tx_line  [NL];
    logic [10:0] sr_p     [NL];
    logic [10:0] sr_reg   [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        uart_tx_controller_if ifc ();
        assign ifc.tx_data  = tx_data[g];
        assign ifc.tx_valid = tx_valid[g];
        assign tx_ready[g]  = ifc.tx_ready;
        assign tx_busy[g]   = ifc.tx_busy;
        assign tx_done[g]   = ifc.tx_done;
        assign sr_q0[g]     = sr_reg[g][0];

        uart_tx_controller #(
            .CLKS_PER_BIT (CPB_L[g]),
            .PARITY_EN    (PEN_L[g]),
            .PARITY_ODD   (ODD_L[g])
        ) dut (
            .clock_i     (clk),
            .reset_ni    (rst_n),
            .host        (ifc),
            .sr_load_o   (sr_load[g]),
            .sr_shift_o  (sr_shift[g]),
            .sr_data_p_o (sr_p[g]),
            .sr_data_s_o (sr_s[g]),
            .sr_q0_i     (sr_q0[g]),
            .tx_o        (tx_line[g])
        );
    end

    // External shift register: parallel load, or shift right filling from the serial input.
    always @(posedge clk or negedge rst_n) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst_n)           sr_reg[l] <= 11'h7FF;
            else if (sr_load[l])  sr_reg[l] <= sr_p[l];
            else if (sr_shift[l]) sr_reg[l] <= {sr_s[l], sr_reg[l][10:1]};
        end
    end

    // ---------------- model: everything is timed relative to handshake cycle H
    int          cyc = 0;
    int          h        [NL];
    bit          hv       [NL];
    bit          pv       [NL];
    int          done_cyc [NL] = '{-1, -1, -1};
    logic [10:0] m_frame  [NL];

    function automatic logic [10:0] mk_frame(input int l, input logic [7:0] b);
        logic par;
        par = PEN_L[l] ? ((^b) ^ ODD_L[l]) : 1'b1;
        return {1'b1, par, b, 1'b0};
    endfunction

    function automatic bit in_frame(input int l, input int c);
        int d;
        d = c - h[l];
        return hv[l] && (d >= 1) && (d <= 1 + 11 * CPB_L[l]);
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst_n) begin
                hv[l]       <= 1'b0;
                pv[l]       <= 1'b0;
                done_cyc[l] <= -1;
            end else if (tx_valid[l] && !in_frame(l, cyc)) begin
                h[l]        <= cyc;
                hv[l]       <= 1'b1;
                pv[l]       <= 1'b1;
                m_frame[l]  <= mk_frame(l, tx_data[l]);
                done_cyc[l] <= cyc + 2 + 11 * CPB_L[l];
            end
        end
        cyc <= cyc + 1;
    end

    // ---------------- checking
    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] pin_q    [NL][$];
    logic [10:0] rx_word  [NL];
    int          done_cnt [NL] = '{0, 0, 0};
    int          exp_frames [NL] = '{5, 2, 1};
    bit          final_req  = 1'b0;
    bit          final_done = 1'b0;

    task automatic check(input string what, input int l, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", what, l, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            int          d;
            int          cpb;
            logic        e_rdy, e_busy, e_load, e_shift, e_done, e_tx;
            logic [10:0] e_p;
            cpb     = CPB_L[l];
            d       = cyc - h[l];
            e_rdy   = !in_frame(l, cyc);
            e_busy  = in_frame(l, cyc);
            e_load  = hv[l] && (d == 1);
            e_shift = 1'b0;
            e_done  = (cyc == done_cyc[l]);
            e_tx    = 1'b1;
            e_p     = pv[l] ? m_frame[l] : 11'h7FF;
            if (hv[l] && d >= 2 && d < 2 + 11 * cpb) begin
                e_tx    = m_frame[l][(d - 2) / cpb];
                e_shift = ((d - 2) % cpb == cpb - 1) && ((d - 2) / cpb < 10);
            end
            if (!rst_n) begin
                e_rdy = 1'b1; e_busy = 1'b0; e_load = 1'b0;
                e_shift = 1'b0; e_done = 1'b0; e_tx = 1'b1; e_p = 11'h7FF;
            end

            check("tx_ready",  l, tx_ready[l], e_rdy);
            check("tx_busy",   l, tx_busy[l],  e_busy);
            check("sr_load",   l, sr_load[l],  e_load);
            check("sr_shift",  l, sr_shift[l], e_shift);
            check("tx_done",   l, tx_done[l],  e_done);
            check("tx",        l, tx_line[l],  e_tx);
            check("sr_data_p", l, sr_p[l],     e_p);
            check("sr_data_s", l, sr_s[l],     1'b1);

            if (rst_n && tx_done[l] === 1'b1) begin
                done_cnt[l]++;
                if (l == 0 && hv[0]) check("done_at_H+46", 0, cyc - h[0], 46);
            end

            // Hand-computed frames pin both the presented word and the decoded line.
            if (rst_n && hv[l]) begin
                if (d == 1 && pin_q[l].size() > 0)
                    check("frame_at_load", l, sr_p[l], pin_q[l][0]);
                if (d >= 2 && d < 2 + 11 * cpb && ((d - 2) % cpb == cpb / 2))
                    rx_word[l][(d - 2) / cpb] = tx_line[l];
                if (d == 2 + 11 * cpb && pin_q[l].size() > 0)
                    check("frame_on_line", l, rx_word[l], pin_q[l].pop_front());
            end
        end

        if (final_req && !final_done) begin
            for (int l = 0; l < NL; l++) begin
                check("frames_sent",    l, done_cnt[l],       exp_frames[l]);
                check("pins_consumed",  l, pin_q[l].size(),   0);
            end
            final_done = 1'b1;
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int l, input logic [7:0] b);
        tx_data[l]  = b;
        tx_valid[l] = 1'b1;
        tick();
        tx_valid[l] = 1'b0;
        tx_data[l]  = ~b;
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            tx_data[l]  = 8'h00;
            tx_valid[l] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Even parity, 4 clocks/bit: 0x55 has four ones, parity 0.
        pin_q[0].push_back(11'h4AA);
        send(0, 8'h55);
        repeat (50) tick();

        // Odd parity (5 clocks/bit) and no parity (2 clocks/bit) in parallel.
        pin_q[1].push_back(11'h402);
        pin_q[2].push_back(11'h602);
        tx_data[1] = 8'h01; tx_valid[1] = 1'b1;
        tx_data[2] = 8'h01; tx_valid[2] = 1'b1;
        tick();
        tx_valid[1] = 1'b0; tx_valid[2] = 1'b0;
        repeat (60) tick();
        pin_q[1].push_back(11'h606);
        send(1, 8'h03);
        repeat (60) tick();

        // Back-to-back: valid held from H through the done cycle H+46.
        pin_q[0].push_back(11'h54A);
        pin_q[0].push_back(11'h478);
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        tick();
        tx_data[0]  = 8'h3C;
        repeat (46) tick();
        tx_valid[0] = 1'b0;
        repeat (50) tick();

        // A request while busy must be ignored.
        pin_q[0].push_back(11'h424);
        send(0, 8'h12);
        repeat (20) tick();
        tx_data[0]  = 8'hFF;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        repeat (40) tick();

        // Reset during bit 4 (cycle H+19), then a clean frame.
        send(0, 8'hC3);
        repeat (18) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        pin_q[0].push_back(11'h700);
        send(0, 8'h80);
        repeat (50) tick();

        final_req = 1'b1;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
